// File: rtl/pucch1_occ_phase_gen.sv
// PUCCH format 1 time-domain OCC phase sequence generator (one or two hops, nSF 1..7).
// Optional element tagging ports o_hop/o_m are enabled with `define PUCCH1_OCC_TAG_EN.
module pucch1_occ_phase_gen #(
  parameter int unsigned PHASE_RES = 420,
  parameter int unsigned PHI_W     = $clog2(PHASE_RES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_hop_en,
  input  logic [2:0]       i_nsf0,
  input  logic [2:0]       i_occi0,
  input  logic [2:0]       i_nsf1,
  input  logic [2:0]       i_occi1,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [PHI_W-1:0] o_phi,
  output logic             o_hop_last,
  output logic             o_last,
  output logic             o_busy,
`ifdef PUCCH1_OCC_TAG_EN
  output logic             o_hop,
  output logic [2:0]       o_m,
`endif
  output logic             o_err
);

  generate
    if (PHASE_RES % 420 != 0) begin : g_bad_res
      $error("PHASE_RES must be a multiple of 420");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HOP0, HOP1} state_t;

  localparam logic [PHI_W:0]   RES_EXT = (PHI_W+1)'(PHASE_RES);
  localparam logic [PHI_W-1:0] HALF    = PHI_W'(PHASE_RES / 2);

  function automatic logic [PHI_W-1:0] step_of(input logic [2:0] nsf, input logic [2:0] occi);
    int unsigned q;
    case (nsf)
      3'd1:    q = PHASE_RES / 1;
      3'd2:    q = PHASE_RES / 2;
      3'd3:    q = PHASE_RES / 3;
      3'd4:    q = PHASE_RES / 4;
      3'd5:    q = PHASE_RES / 5;
      3'd6:    q = PHASE_RES / 6;
      3'd7:    q = PHASE_RES / 7;
      default: q = 0;
    endcase
    return PHI_W'(32'(occi) * q);
  endfunction

  function automatic logic legal(input logic [2:0] nsf, input logic [2:0] occi);
    return (nsf != 3'd0) && (occi < nsf);
  endfunction

  state_t           state, state_nx;
  logic             hop_en_q;
  logic [2:0]       nsf1_q, occi1_q, cur_nsf, cur_occi, m;
  logic [PHI_W-1:0] step, step1_q, phi, phi_nx;
  logic [PHI_W:0]   sum;
  logic [2:0]       m_inc;
  logic             err, cfg_ok, busy, hop_last, xfer;

  assign busy     = (state != IDLE);
  assign cfg_ok   = legal(i_nsf0, i_occi0) && (!i_hop_en || legal(i_nsf1, i_occi1));
  assign hop_last = busy && (m == cur_nsf - 3'd1);
  assign xfer     = busy && i_ready;
  assign m_inc    = m + 3'd1;
  assign sum      = {1'b0, phi} + {1'b0, step};

  // nSF=4 uses the Walsh rows directly: row bit k selects m bit k, h on odd parity.
  always_comb begin
    phi_nx = '0;
    if (cur_nsf == 3'd4)
      phi_nx = (^(cur_occi & m_inc)) ? HALF : '0;
    else if (sum >= RES_EXT)
      phi_nx = PHI_W'(sum - RES_EXT);
    else
      phi_nx = PHI_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_start && cfg_ok) state_nx = HOP0;
      HOP0: if (xfer && hop_last) state_nx = hop_en_q ? HOP1 : IDLE;
      HOP1: if (xfer && hop_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hop_en_q <= 1'b0;
      nsf1_q   <= '0;
      occi1_q  <= '0;
      step1_q  <= '0;
      cur_nsf  <= '0;
      cur_occi <= '0;
      step     <= '0;
      m        <= '0;
      phi      <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (i_start) begin
          if (cfg_ok) begin
            hop_en_q <= i_hop_en;
            cur_nsf  <= i_nsf0;
            cur_occi <= i_occi0;
            step     <= step_of(i_nsf0, i_occi0);
            nsf1_q   <= i_nsf1;
            occi1_q  <= i_occi1;
            step1_q  <= step_of(i_nsf1, i_occi1);
            m        <= '0;
            phi      <= '0;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (xfer) begin
        if (hop_last) begin
          m   <= '0;
          phi <= '0;
          if (state == HOP0 && hop_en_q) begin
            cur_nsf  <= nsf1_q;
            cur_occi <= occi1_q;
            step     <= step1_q;
          end
        end else begin
          m   <= m_inc;
          phi <= phi_nx;
        end
      end
    end
  end

  assign o_valid    = busy;
  assign o_busy     = busy;
  assign o_phi      = phi;
  assign o_hop_last = hop_last;
  assign o_last     = hop_last && ((state == HOP1) || !hop_en_q);
  assign o_err      = err;
`ifdef PUCCH1_OCC_TAG_EN
  assign o_hop      = (state == HOP1);
  assign o_m        = m;
`endif

endmodule

// File: doc/pucch1_occ_phase_gen.md
Name: pucch1_occ_phase_gen

Overview:
- Generates the block-wise time-domain OCC phase sequence phi(m) for PUCCH format 1, for any nSF in 1..7, including nSF = 5 and 7.
- Covers one or two frequency hops per start, each hop with its own nSF and OCC index.
- Phases are emitted as integers in units of 2*pi/PHASE_RES on a valid/ready stream.
- Sits between the PUCCH1 config decode and the symbol-wise spreading multiplier/phase-rotator.

Parameters:
- PHASE_RES, 420: phase resolution, one full turn = PHASE_RES. Must be a multiple of 420 (LCM of 1..7); any other value is an elaboration error.
- PHI_W, $clog2(PHASE_RES): output phase width, 9 at default.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_hop_en  in  1  1 = two hops (hop0 then hop1), 0 = hop0 only
- i_nsf0  in  3  hop0 spreading factor, legal 1..7
- i_occi0  in  3  hop0 OCC index, legal 0..i_nsf0-1
- i_nsf1  in  3  hop1 spreading factor; ignored when i_hop_en = 0
- i_occi1  in  3  hop1 OCC index
- i_ready  in  1  downstream ready
- o_valid  out  1  o_phi valid
- o_phi  out  PHI_W  phi(m), range 0..PHASE_RES-1
- o_hop_last  out  1  element is m = nSF-1 of the current hop
- o_last  out  1  final element of the whole sequence
- o_busy  out  1  sequence in progress
- o_err  out  1  one-cycle pulse: start rejected due to illegal config

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. On rst: FSM goes to IDLE; o_valid, o_phi, o_hop_last, o_last, o_busy and o_err all go to 0. rst mid-sequence aborts the sequence with no further outputs. rst has priority over everything.
- FSM states: IDLE, HOP0, HOP1.
- IDLE:
  - On i_start, latch all config inputs.
  - Legality: a hop is legal iff 1 <= nSF <= 7 and occi < nSF. hop1 is checked only when i_hop_en = 1.
  - Illegal: o_err = 1 for exactly the next cycle, stay in IDLE, no o_valid.
  - Legal: go to HOP0 with m = 0 and phi = 0. o_valid and o_busy rise the cycle after i_start (latency 1).
- i_start while in HOP0/HOP1 is ignored. Config inputs are don't-care after the latch.
- Step computation: at latch time, step = occi * (PHASE_RES/nSF). PHASE_RES/nSF comes from a constant table indexed by nSF; no runtime divider.
- Handshake:
  - Transfer when o_valid & i_ready.
  - While o_valid = 1 and i_ready = 0, o_phi, o_hop_last and o_last hold stable.
  - o_valid stays high until the transfer.
  - No bubbles: the next element is presented in the cycle after a transfer.
- Phase update per transfer:
  - For nSF != 4: phi <= phi + step; if the sum >= PHASE_RES, subtract PHASE_RES. A single conditional subtract suffices since step < PHASE_RES. Internal sum width is PHI_W+1.
  - For nSF = 4: Walsh table with h = PHASE_RES/2:
    - occi0 = 0,0,0,0
    - occi1 = 0,h,0,h
    - occi2 = 0,0,h,h
    - occi3 = 0,h,h,0
  - For nSF = 1: single element, phi = 0.
- End of hop: o_hop_last = 1 when m = nSF-1.
  - Transfer of the hop0 last element with hop_en = 1: go to HOP1 with m = 0, phi = 0, next cycle.
  - Otherwise: o_last = 1 on that element; after its transfer, go to IDLE with o_valid = 0 and o_busy = 0 next cycle.
  - In HOP1, o_last = o_hop_last.
- o_busy is high in HOP0 and HOP1.
- A start accepted in the same cycle the FSM returns to IDLE is not possible. IDLE lasts at least one cycle between sequences.

Optional Feature:
- Macro: PUCCH1_OCC_TAG_EN.
- Defined: adds two output ports, both valid with o_valid:
  - o_hop (1 bit): 0 = hop0, 1 = hop1.
  - o_m (3 bits): current element index m.
  - Both reset to 0 and hold under backpressure.
- Undefined: the ports do not exist; all other behaviour is identical.

Test Plan:
- nSF0 = 7, occi0 = 3, hop_en = 0, ready = 1 -> o_phi = 0, 180, 360, 120, 300, 60, 240 on consecutive cycles; o_last on 240; o_busy falls next cycle.
- nSF0 = 5, occi0 = 2 -> 0, 168, 336, 84, 252; nSF0 = 4, occi0 = 3 -> 0, 210, 210, 0.
- hop_en = 1, nSF0 = 2/occi0 = 1, nSF1 = 3/occi1 = 2:
  - Outputs 0, 210 | 0, 280, 140.
  - o_hop_last on 210 and on 140; o_last only on 140.
- nSF0 = 6, occi0 = 5, i_ready toggled 1,0,0,1,...:
  - Sequence 0, 350, 280, 210, 140, 70.
  - o_phi held stable while ready = 0; no element lost or duplicated.
- nSF0 = 3/occi0 = 3, and separately nSF0 = 0 -> o_err one-cycle pulse, o_valid stays 0. Then hop_en = 1 with nSF1 = 2/occi1 = 2 -> o_err. A legal start afterwards runs normally.
- rst asserted after the 3rd transfer of an nSF = 7 run -> all outputs 0 next cycle. A new start yields a fresh sequence from phi = 0; an i_start issued mid-sequence is ignored.
